// File: rtl/serial_mag_comparator.sv
// Serial magnitude comparator.
// Combines per-bit compare results, streamed MSB first, into one registered
// word-level GT/EQ/LT result. The first differing bit decides the outcome,
// and bits that are not one-hot raise a sticky error flag.
module serial_mag_comparator #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bit_valid,
  input  logic aGTb_bit,
  input  logic aEQb_bit,
  input  logic aLTb_bit,
  output logic busy,
  output logic done,
  output logic aGTb,
  output logic aEQb,
  output logic aLTb,
  output logic err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    FIN
  } state_t;

  // Decision latch: NONE until the first differing bit locks GT or LT.
  typedef enum logic [1:0] {
    DEC_NONE,
    DEC_GT,
    DEC_LT
  } dec_t;

  state_t        state_q, state_d;
  dec_t          dec_q, dec_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          gt_q, gt_d;
  logic          eq_q, eq_d;
  logic          lt_q, lt_d;
  logic          err_q, err_d;
  logic          bit_onehot;

  // A legal bit result asserts exactly one of the three compare lines.
  assign bit_onehot = ({aGTb_bit, aEQb_bit, aLTb_bit} == 3'b100) ||
                      ({aGTb_bit, aEQb_bit, aLTb_bit} == 3'b010) ||
                      ({aGTb_bit, aEQb_bit, aLTb_bit} == 3'b001);

  // Next-state and output logic for the IDLE -> CMP -> FIN sequence.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    dec_d   = dec_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        // Bit inputs sampled together with start are not part of the word.
        if (start) begin
          state_d = CMP;
          cnt_d   = '0;
          err_d   = 1'b0;
          dec_d   = DEC_NONE;
          busy_d  = 1'b1;
        end
      end

      CMP: begin
        // start is ignored here; bit_valid=0 is a stall.
        if (bit_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (!bit_onehot) begin
            err_d = 1'b1;
          end else if (dec_q == DEC_NONE) begin
            if (aGTb_bit)      dec_d = DEC_GT;
            else if (aLTb_bit) dec_d = DEC_LT;
          end
          if (cnt_q == LAST_IDX) begin
            state_d = FIN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            // NOTE: dec_d is read back after its blocking update above, so a
            // decision locked by the final bit reaches the result registers.
            gt_d    = (dec_d == DEC_GT);
            lt_d    = (dec_d == DEC_LT);
            eq_d    = (dec_d == DEC_NONE);
          end
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dec_q   <= DEC_NONE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values regardless of statement order.
      state_q <= state_d;
      dec_q   <= dec_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      err_q   <= err_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign aGTb = gt_q;
  assign aEQb = eq_q;
  assign aLTb = lt_q;
  assign err  = err_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Self-checking bench for serial_mag_comparator (WIDTH=8).
// Expected results come from plain arithmetic on the A/B words, or from a
// scan of the bit stream when corrupted bits are injected.
module tb_serial_mag_comparator;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic bit_valid = 1'b0;
  logic g_bit = 1'b0;
  logic e_bit = 1'b0;
  logic l_bit = 1'b0;
  logic busy, done, aGTb, aEQb, aLTb, err;

  int n_checks = 0;
  int n_fail   = 0;

  serial_mag_comparator #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bit_valid(bit_valid),
    .aGTb_bit (g_bit),
    .aEQb_bit (e_bit),
    .aLTb_bit (l_bit),
    .busy     (busy),
    .done     (done),
    .aGTb     (aGTb),
    .aEQb     (aEQb),
    .aLTb     (aLTb),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Asynchronous reset: outputs clear with no clock edge, release on an edge.
  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, aGTb, aEQb, aLTb, err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_async: got %b expected 000000", {busy, done, aGTb, aEQb, aLTb, err});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, aGTb, aEQb, aLTb, err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_release: got %b expected 000000", {busy, done, aGTb, aEQb, aLTb, err});
    end
  endtask

  // One full comparison of words a and b. bad_mask marks bit positions whose
  // triple is replaced by bad_val. vmode: 0 = valid every cycle, 1 = valid on
  // alternate cycles, 2 = random valid. spam holds start high throughout.
  task automatic run_cmp(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] bad_mask, input logic [2:0] bad_val,
                         input int vmode, input bit spam);
    logic [2:0] trips [8];
    logic [2:0] exp_res;
    logic       exp_err;
    int dec, idx, cyc, last_valid, exp_cyc;
    bit got_done, v;

    for (int i = 0; i < 8; i++) begin
      if (a[i] && !b[i])    trips[i] = 3'b100;
      else if (a[i] == b[i]) trips[i] = 3'b010;
      else                   trips[i] = 3'b001;
      if (bad_mask[i]) trips[i] = bad_val;
    end

    // Reference: clean words compare arithmetically; corrupted streams are
    // scanned MSB first, illegal bits count as equal and flag an error.
    exp_err = 1'b0;
    dec = 0;
    for (int i = 7; i >= 0; i--) begin
      if ($countones(trips[i]) != 1) exp_err = 1'b1;
      else if (dec == 0 && trips[i][2]) dec = 1;
      else if (dec == 0 && trips[i][0]) dec = 2;
    end
    if (bad_mask == 8'h00)
      exp_res = {a > b, a == b, a < b};
    else
      exp_res = {dec == 1, dec == 0, dec == 2};

    // Start cycle: the illegal triple offered alongside start must be ignored.
    @(negedge clk);
    start = 1'b1;
    bit_valid = 1'b1;
    {g_bit, e_bit, l_bit} = 3'b111;
    idx = 7;
    cyc = 0;
    last_valid = 0;
    got_done = 1'b0;

    while (!got_done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        got_done = 1'b1;
      end else begin
        if (cyc == 1) begin
          n_checks++;
          if (busy !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s start_clear: busy=%b err=%b expected busy=1 err=0", name, busy, err);
          end
        end
        start = spam;
        case (vmode)
          0:       v = 1'b1;
          1:       v = cyc[0];
          default: v = 1'($urandom_range(0, 1));
        endcase
        if (v && idx >= 0) begin
          bit_valid = 1'b1;
          {g_bit, e_bit, l_bit} = trips[idx];
          idx--;
          last_valid = cyc;
        end else begin
          bit_valid = 1'b0;
          {g_bit, e_bit, l_bit} = 3'($urandom);
        end
      end
    end

    n_checks++;
    if (!got_done) begin
      n_fail++;
      $display("FAIL %s timeout: no done within %0d cycles", name, cyc);
      start = 1'b0;
      bit_valid = 1'b0;
      return;
    end

    exp_cyc = (vmode == 0) ? 9 : (vmode == 1) ? 16 : last_valid + 1;
    if (cyc != exp_cyc) begin
      n_fail++;
      $display("FAIL %s latency: done at cycle %0d expected %0d", name, cyc, exp_cyc);
    end
    n_checks++;
    if ({aGTb, aEQb, aLTb} !== exp_res || err !== exp_err || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s result: gt/eq/lt=%b err=%b busy=%b expected %b err=%b busy=0",
               name, {aGTb, aEQb, aLTb}, err, busy, exp_res, exp_err);
    end

    // FIN cycle: start and an illegal valid bit must both be ignored.
    start = spam;
    bit_valid = 1'b1;
    {g_bit, e_bit, l_bit} = 3'b111;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s pulse_width: done=%b busy=%b expected 0 0", name, done, busy);
    end
    start = 1'b0;

    // IDLE: valid bits ignored, results and err held, no extra done.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || {aGTb, aEQb, aLTb} !== exp_res || err !== exp_err) begin
        n_fail++;
        $display("FAIL %s hold: done=%b busy=%b res=%b err=%b expected 0 0 %b %b",
                 name, done, busy, {aGTb, aEQb, aLTb}, err, exp_res, exp_err);
      end
    end
    bit_valid = 1'b0;
  endtask

  task automatic test_equal();
    run_cmp("equal_a5", 8'hA5, 8'hA5, 8'h00, 3'b000, 0, 1'b0);
  endtask

  task automatic test_first_diff();
    run_cmp("msb_lock", 8'h80, 8'h7F, 8'h00, 3'b000, 0, 1'b0);
    run_cmp("lsb_only", 8'h10, 8'h11, 8'h00, 3'b000, 0, 1'b0);
  endtask

  task automatic test_stall();
    run_cmp("stall_toggle", 8'h3C, 8'h3D, 8'h00, 3'b000, 1, 1'b0);
  endtask

  task automatic test_err();
    run_cmp("err_bit3", 8'h5A, 8'h5A, 8'h08, 3'b110, 0, 1'b0);
    run_cmp("err_cleared", 8'h01, 8'h02, 8'h00, 3'b000, 0, 1'b0);
    run_cmp("err_zero_lsb", 8'hF0, 8'hF0, 8'h01, 3'b000, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_cmp("start_spam_gt", 8'hC3, 8'h42, 8'h00, 3'b000, 0, 1'b1);
    run_cmp("start_spam_lt", 8'h07, 8'h70, 8'h00, 3'b000, 1, 1'b1);
  endtask

  // Reset after four consumed bits aborts the comparison without done.
  task automatic test_reset_mid();
    int seen_done;
    @(negedge clk);
    start = 1'b1;
    bit_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      bit_valid = 1'b1;
      {g_bit, e_bit, l_bit} = 3'b010;
    end
    @(negedge clk);
    bit_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, aGTb, aEQb, aLTb, err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %b expected 000000", {busy, done, aGTb, aEQb, aLTb, err});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    bit_valid = 1'b1;
    {g_bit, e_bit, l_bit} = 3'b100;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    bit_valid = 1'b0;
    n_checks++;
    if (seen_done != 0) begin
      n_fail++;
      $display("FAIL reset_mid_abort: busy/done seen %0d cycles expected 0", seen_done);
    end
    run_cmp("after_reset", 8'h9E, 8'h9C, 8'h00, 3'b000, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] a, b, mask;
    for (int t = 0; t < 20; t++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : 8'($urandom);
      mask = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      run_cmp("random", a, b, mask, 3'($urandom), 2, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_equal();
    test_first_diff();
    test_stall();
    test_err();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_mag_comparator.md
SERIAL_MAG_COMPARATOR -- requirements
Module: serial_mag_comparator

Interface
REQ-001 Parameter: WIDTH, default 8, number of bit positions per comparison (legal range 1..255).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  begin a new WIDTH-bit comparison.
REQ-005 bit_valid  input  1  qualifies the three per-bit compare inputs this cycle.
REQ-006 aGTb_bit  input  1  1-bit comparator "a greater" result for the current bit, MSB first.
REQ-007 aEQb_bit  input  1  1-bit comparator "equal" result for the current bit.
REQ-008 aLTb_bit  input  1  1-bit comparator "a less" result for the current bit.
REQ-009 busy  output  1  high while a comparison is in progress.
REQ-010 done  output  1  one-cycle pulse when the final result is available.
REQ-011 aGTb  output  1  registered word result: A > B.
REQ-012 aEQb  output  1  registered word result: A == B.
REQ-013 aLTb  output  1  registered word result: A < B.
REQ-014 err  output  1  sticky flag: a qualified bit input was not one-hot.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, CMP and FIN.
REQ-016 IDLE->CMP SHALL occur on start=1; the cycle that start is sampled SHALL clear the bit counter, err and the decision latch, and set busy=1 on the next edge.
REQ-017 bit_valid in the same cycle as start SHALL be ignored; consumption SHALL begin the cycle after start.
REQ-018 In CMP, each cycle with bit_valid=1 SHALL consume one bit and increment a counter of width ceil(log2(WIDTH+1)); bit_valid=0 SHALL stall with no state change.
REQ-019 Decision rule: the first consumed bit with aGTb_bit=1 or aLTb_bit=1 SHALL lock the decision to GT or LT; later bits SHALL not change a locked decision.
REQ-020 Later bits SHALL still be consumed and counted after a decision is locked; there is no early termination.
REQ-021 A qualified bit whose {aGTb_bit,aEQb_bit,aLTb_bit} is not exactly one-hot SHALL set err=1 and be treated as equal for the decision.
REQ-022 CMP->FIN SHALL occur on the edge that consumes bit number WIDTH.
REQ-023 On entering FIN, aGTb/aEQb/aLTb SHALL load the decision (EQ if never locked) and be exactly one-hot.
REQ-024 done SHALL be 1 for exactly the cycle spent in FIN, and busy SHALL drop to 0 on that same edge.
REQ-025 FIN->IDLE SHALL occur unconditionally after one cycle; start sampled in FIN SHALL be ignored.
REQ-026 Latency: with bit_valid held high, done SHALL assert WIDTH+1 cycles after the start edge.
REQ-027 start=1 while in CMP SHALL be ignored; the current comparison SHALL continue.
REQ-028 Result outputs and err SHALL hold their values from FIN until the next accepted start clears them (err to 0; aGTb/aEQb/aLTb are cleared only in the sense of being reloaded in the next FIN).
REQ-029 bit_valid in IDLE or FIN SHALL be ignored.

Reset
REQ-030 rst_n=0 SHALL immediately, without a clock edge, force state=IDLE, counter=0, busy=0, done=0, aGTb=0, aEQb=0, aLTb=0, err=0, and clear the decision latch.
REQ-031 Reset asserted mid-comparison SHALL abort it with no done pulse; the first comparison after release requires a new start.
REQ-032 Deassertion SHALL take effect at the first rising clk edge after rst_n rises.

Verification
REQ-033 WIDTH=8, A=8'hA5 and B=8'hA5 streamed back-to-back -> done at cycle 9 after start, with aEQb=1, aGTb=0, aLTb=0, err=0.
REQ-034 A=8'h80 and B=8'h7F (MSB GT, remaining bits LT) -> aGTb=1 only, confirming the decision locks on the first differing bit.
REQ-035 A=8'h3C and B=8'h3D with bit_valid toggling 1,0,1,0... -> aLTb=1, done 16 cycles after start, counter advances only on valid cycles.
REQ-036 Bit 3 driven as {1,1,0} with all other bits equal -> err=1 and aEQb=1; err clears on the next start.
REQ-037 rst_n pulsed low after 4 bits are consumed -> outputs go to 0 asynchronously and no done pulse occurs; a fresh start then gives a correct result.
REQ-038 start re-asserted during CMP and during FIN -> ignored, with a single done pulse per accepted start.
